// File: rtl/display_pkg.sv
// Shared constants and the active-low hex glyph table for the 4-digit 7-segment display.
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic seg_t hex_to_seg(input nibble_t v);
    seg_t s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_step_sync.sv
// Button to single-cycle step pulse: 2-flop synchronizer, optional debounce (DEBOUNCE_EN), rising-edge detect.
// Latency: pin rise to pulse 2 clk (+DEBOUNCE_CYCLES with DEBOUNCE_EN); no backpressure, one pulse per press.
module btn_step_sync #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic step
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt holds how many consecutive cycles sync2 has disagreed with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  logic unused_db;
  assign unused_db = ^DEBOUNCE_CYCLES;
  assign level     = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign step = level & ~level_q;

endmodule

// File: rtl/reg_bank_display_reader.sv
// Bank read-back display: button walks the read index, captured word is scanned as 4 hex digits.
// Latency: pin to rd_addr 3 clk (+DEBOUNCE_CYCLES with DEBOUNCE_EN); new value shown from the next frame start.
// Backpressure: none; combinational bank read, display free-runs. DEBOUNCE_EN selects button debouncing.
module reg_bank_display_reader
  import display_pkg::*;
#(
  parameter int REFRESH_DIV     = 100000,
  parameter int NUM_REGS        = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step_btn,
  input  logic                        displayctrl,
  input  logic [15:0]                 rd_data,
  input  logic [15:0]                 alu_value,
  output logic [$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [$clog2(NUM_REGS)-1:0] idx_leds,
  output logic [6:0]                  seg,
  output logic [3:0]                  an
);

  localparam int            IDX_W      = $clog2(NUM_REGS);
  localparam int            PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam int            DW         = $clog2(NUM_DIGITS);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [3:0]    AN_ONE     = 4'b0001;

  logic             step;
  logic [IDX_W-1:0] idx;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [DW-1:0]    digit;
  logic [15:0]      held;
  nibble_t          nib;

  btn_step_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (step_btn),
    .step (step)
  );

  assign tick = (presc == PRESC_LAST);
  assign nib  = held[{digit, 2'b00} +: 4];

  // held only changes after the last digit of a frame is latched, so a frame never mixes two words.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      presc <= '0;
      digit <= '0;
      held  <= 16'h0000;
      an    <= AN_OFF;
      seg   <= SEG_BLANK;
    end else begin
      if (step) begin
        idx <= idx + IDX_W'(1);
      end
      if (tick) begin
        presc <= '0;
        digit <= digit + DW'(1);
        an    <= ~(AN_ONE << digit);
        seg   <= hex_to_seg(nib);
        if (digit == DIGIT_LAST) begin
          held <= displayctrl ? alu_value : rd_data;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign rd_addr  = idx;
  assign idx_leds = idx;

endmodule

// File: tb/tb_reg_bank_display_reader.sv
// Randomized bench for reg_bank_display_reader against a cycle-count reference model.
module tb_reg_bank_display_reader;

  localparam int DIV   = 4;
  localparam int NREG  = 32;
  localparam int DB    = 8;
  localparam int FRAME = 4 * DIV;
`ifdef DEBOUNCE_EN
  localparam int PLEN  = DB + 4;
`else
  localparam int PLEN  = 1;
`endif

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [3:0] EXP_AN   [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
  localparam logic [6:0] EXP_1A2F [4]  = '{7'h0E, 7'h24, 7'h08, 7'h79};
  localparam logic [6:0] EXP_BEEF [4]  = '{7'h0E, 7'h06, 7'h06, 7'h03};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_btn = 1'b0;
  logic        displayctrl = 1'b0;
  logic [15:0] alu_value = 16'h0000;
  logic [15:0] rd_data;
  logic [4:0]  rd_addr;
  logic [4:0]  idx_leds;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bank [NREG];

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  assign rd_data = bank[rd_addr];

  reg_bank_display_reader #(
    .REFRESH_DIV     (DIV),
    .NUM_REGS        (NREG),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step_btn    (step_btn),
    .displayctrl (displayctrl),
    .rd_data     (rd_data),
    .alu_value   (alu_value),
    .rd_addr     (rd_addr),
    .idx_leds    (idx_leds),
    .seg         (seg),
    .an          (an)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pin history, cycles since reset, slot number = cycles / DIV.
  int          m_c;
  logic [4:0]  m_idx;
  logic [15:0] m_held;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        hist [16];
  logic        m_lvl;
  logic        m_lvl_p;

  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 16; j++) hist[j] = 1'b0;
      m_c = 0; m_idx = '0; m_held = '0; m_an = 4'hF; m_seg = 7'h7F;
      m_lvl = 1'b0; m_lvl_p = 1'b0;
    end else begin
      logic       stepped;
      logic       flip;
      logic [1:0] d;
      for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = step_btn;
`ifdef DEBOUNCE_EN
      stepped = m_lvl & ~m_lvl_p;
      flip = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (hist[j] == m_lvl) flip = 1'b0;
      m_lvl_p = m_lvl;
      if (flip) m_lvl = ~m_lvl;
`else
      flip = 1'b0;
      stepped = hist[2] & ~hist[3];
`endif
      m_c++;
      if (m_c % DIV == 0) begin
        d = 2'((m_c / DIV - 1) % 4);
        m_an = 4'hF;
        m_an[d] = 1'b0;
        m_seg = GLYPH[m_held[{d, 2'b00} +: 4]];
        if (d == 2'd3) m_held = displayctrl ? alu_value : bank[m_idx];
      end
      if (stepped) m_idx = m_idx + 5'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("an", 32'(an), 32'(m_an));
      chk("seg", 32'(seg), 32'(m_seg));
      chk("rd_addr", 32'(rd_addr), 32'(m_idx));
      chk("idx_leds", 32'(idx_leds), 32'(m_idx));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int len);
    step_btn = 1'b1;
    cyc(len);
    step_btn = 1'b0;
    cyc(len + 12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < NREG; i++) bank[i] = 16'($urandom);
    bank[0] = 16'h1A2F;
    cyc(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_addr", 32'(rd_addr), 32'h0);
    chk_on = 1'b1;
    rst = 1'b0;

    for (int i = 1; i < DIV; i++) begin
      cyc(1);
      chk("blank_an", 32'(an), 32'hF);
    end
    cyc(1);
    chk("first_an", 32'(an), 32'hE);
    chk("first_seg", 32'(seg), 32'h40);

    cyc(FRAME);
    for (int i = 0; i < 4; i++) begin
      chk("f1a2f_an", 32'(an), 32'(EXP_AN[i]));
      chk("f1a2f_seg", 32'(seg), 32'(EXP_1A2F[i]));
      if (i < 3) cyc(DIV);
    end

    repeat (3) press(PLEN);
    chk("three_steps", 32'(rd_addr), 32'd3);
    press(50);
    chk("held_btn", 32'(idx_leds), 32'd4);
    repeat (27) press(PLEN);
    chk("idx31", 32'(rd_addr), 32'd31);
    press(PLEN);
    chk("wrap", 32'(rd_addr), 32'd0);

    bank[0] = 16'h0000;
    displayctrl = 1'b1;
    alu_value = 16'hBEEF;
    w = 0;
    do begin
      cyc(1);
      w++;
    end while ((m_c % FRAME) != 0 && w < 2 * FRAME);
    chk("frame_wait", 32'(w < 2 * FRAME), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(DIV);
      chk("beef_seg", 32'(seg), 32'(EXP_BEEF[i]));
      if (i == 1) begin
        displayctrl = 1'b0;
        alu_value = 16'h1234;
      end
    end
    cyc(DIV);
    chk("after_toggle", 32'(seg), 32'h40);

    repeat (7) press(PLEN);
    chk("idx7", 32'(rd_addr), 32'd7);
    cyc(DIV + 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    for (int i = 0; i < 4; i++) begin
      cyc(DIV);
      chk("held_zero", 32'(seg), 32'h40);
    end

`ifdef DEBOUNCE_EN
    step_btn = 1'b1;
    cyc(5);
    step_btn = 1'b0;
    cyc(20);
    chk("glitch", 32'(rd_addr), 32'd0);
    press(12);
    chk("db_press", 32'(rd_addr), 32'd1);
`endif

    repeat (150) begin
      case ($urandom_range(0, 3))
        0: press($urandom_range(1, 20));
        1: begin
          displayctrl = 1'($urandom);
          alu_value = 16'($urandom);
          cyc($urandom_range(1, 20));
        end
        2: begin
          bank[$urandom_range(0, NREG - 1)] = 16'($urandom);
          cyc(1);
        end
        default: cyc($urandom_range(1, 30));
      endcase
    end

    cyc(2);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_display_reader.md
Name: reg_bank_display_reader

Overview:
Read-side companion to the register-bank write path. The write path is the FSM driving addr_rd, WEreg and the mux into the bank. This block drives a bank read address and captures the 16-bit read data. It scans the value as 4 hex digits onto a multiplexed, active-low 7-segment display. A step button walks the address 0..31, and displayctrl switches the display to the live ALU result instead.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2
NUM_REGS, 32, number of bank registers addressable; power of two
DEBOUNCE_CYCLES, 500000, stable-level cycles required on step_btn (used only with DEBOUNCE_EN)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
step_btn  input  1  asynchronous push button; each press advances the read index
displayctrl  input  1  0 = show bank register at index, 1 = show alu_value
rd_data  input  16  bank read data for rd_addr (combinational bank read)
alu_value  input  16  live ALU result
rd_addr  output  5  registered bank read address
idx_leds  output  5  current index, mirrors rd_addr
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  4  digit anodes, active-low, one-hot-low

Behaviour:
- Reset: this is a synchronous, active-high reset on rst, sampled at the rising edge of clk. It applies at any cycle, including mid-scan or mid-debounce. All of the following take their reset values on the next edge:
  - idx=0, rd_addr=0, idx_leds=0
  - prescaler=0, digit=0, held=16'h0000
  - sync flops=0, debounce state cleared
  - an=4'b1111, seg=7'h7F (blank)
- Button path:
  - 2-flop synchronizer on step_btn, then a rising-edge detector.
  - One edge gives one step: idx <= idx+1, and rd_addr/idx_leds update on the same edge.
  - Wrap-around: idx 31 -> 0.
  - A held button gives exactly one step.
- Prescaler: counts 0..REFRESH_DIV-1. tick=1 for the single cycle where count==REFRESH_DIV-1; the count then wraps to 0.
- Digit counter: 2 bits, advances on tick, 3 -> 0.
  - Frame start is tick with digit==3.
  - At frame start, held <= (displayctrl ? alu_value : rd_data).
  - held is the only source for the digits, so no tearing occurs within a frame.
- Outputs: registered, updated on tick.
  - an: digit 0 -> 4'b1110 (held[3:0]), digit 1 -> 4'b1101 (held[7:4]), digit 2 -> 4'b1011, digit 3 -> 4'b0111 (held[15:12]).
  - seg = active-low hex glyph of the selected nibble.
  - First non-blank output appears REFRESH_DIV cycles after reset release, on digit 0 with held=0, showing "0".
- Latency: a step edge changes rd_addr 3 clk after the pin rises (2 sync flops plus 1 register). The new value appears at the next frame start, at most 4*REFRESH_DIV cycles later.
- Simultaneous step and frame start: capture uses rd_data for the pre-step rd_addr. The new register is shown one frame later.
- displayctrl toggle takes effect at the next frame start only.
- No other state; no handshake with the bank (read is combinational, no wait state).

Optional Feature:
DEBOUNCE_EN
- Defined: a counter sits between the synchronizer and the edge detector. The debounced level changes only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles. Glitches shorter than that are ignored. Step latency grows by DEBOUNCE_CYCLES.
- Undefined: the synced level feeds the edge detector directly; no counter is synthesized.

Decomposition:
- Package display_pkg: NUM_DIGITS=4, SEG_BLANK=7'h7F, AN_OFF=4'hF, and a function hex_to_seg(logic [3:0]) returning the active-low glyph table 0-F.
- One sub-module: btn_step_sync, containing synchronizer, optional debounce and edge detect, with a 1-cycle pulse output.
- Scan, capture and index logic stay in the top.

Test Plan:
- Reset with REFRESH_DIV=4, run 4 clk -> an=1111, seg=7F. At cycle 4, an=1110 and seg=7'h40 ("0").
- Bank model reg[0]=16'h1A2F, step_btn never pressed, run 2 frames -> an sequence 1110/1101/1011/0111 showing F, 2, A, 1 (7'h0E, 7'h24, 7'h08, 7'h79).
- Pulse step_btn 1 cycle, 3 times -> rd_addr/idx_leds = 3. Hold the button 50 cycles -> exactly one increment.
- idx=31 plus one press -> rd_addr=0.
- displayctrl=1, alu_value=16'hBEEF, rd_data=16'h0000 -> after the next frame start the digits show F, E, E, B. displayctrl toggled mid-frame -> no change until the frame boundary.
- Assert rst mid-frame with idx=7 -> next edge idx=0, an=1111, held=0. With DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle glitch gives no step; a 12-cycle press gives one step.
